// File: rtl/tmrg_ser8_tx_pkg.sv
// Shared definitions for the 8-bit serial link (transmitter and receiver).
// The PRBS7 constants are consumed only when TMRG_SER8_TX_PRBS_EN is defined.
package tmrg_ser8_tx_pkg;

  typedef logic [7:0] word_t;

  localparam word_t      IDLE_WORD_DEF = 8'hBC;

  // PRBS7, x^7 + x^6 + 1: feedback from stages 7 and 6
  localparam logic [6:0] PRBS7_SEED    = 7'h7F;
  localparam logic [6:0] PRBS7_TAPS    = 7'b110_0000;

  function automatic logic [6:0] prbs7_next(input logic [6:0] s);
    return {s[5:0], ^(s & PRBS7_TAPS)};
  endfunction

endpackage

// File: rtl/tmrg_bit_delay8.sv
// Programmable 0..7 clock delay of a single bit.
// sel = 0 passes din straight through; sel = k returns din from k clocks ago.
// Seven register stages cover the full range: the longest delay (7) is dly[6],
// so an eighth stage would never be tapped.
module tmrg_bit_delay8 (
  input  logic       clk,
  input  logic       rstn,
  input  logic       din,
  input  logic [2:0] sel,
  output logic       dout
);

  logic [6:0] dly;

  // shift history of din, newest bit in dly[0]
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) dly <= '0;
    else       dly <= {dly[5:0], din};
  end

  assign dout = (sel == 3'd0) ? din : dly[sel - 3'd1];

endmodule

// File: rtl/tmrg_ser8_tx.sv
// Word-to-serial transmitter: 8-bit words in on valid/ready, MSB-first serial
// out with a programmable 0..7 bit skew and an idle word when nothing is offered.
// Registers are written single-copy; the tmrg flow triplicates all state
// (default triplicate) when the hardened netlist is generated.
// Optional build macro TMRG_SER8_TX_PRBS_EN adds a prbs_mode input that swaps
// the data path for a free-running PRBS7 source.
module tmrg_ser8_tx
  import tmrg_ser8_tx_pkg::*;
#(
  parameter word_t IDLE_WORD = IDLE_WORD_DEF,
  parameter int    CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       phase_shift,
  output logic             sout,
  output logic             frame,
  output logic [CNT_W-1:0] idle_cnt,
`ifdef TMRG_SER8_TX_PRBS_EN
  input  logic             prbs_mode,
`endif
  input  logic             idle_clr
);

  logic [2:0] bitcnt;
  word_t      shreg;
  logic [2:0] phase_q;
  logic       raw;
  logic       frame_raw;
  logic       boundary;
  logic       prbs_on;
  logic       take;
  logic       idle_ins;

`ifdef TMRG_SER8_TX_PRBS_EN
  logic [6:0] lfsr;

  // free-running PRBS7 generator
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lfsr <= PRBS7_SEED;
    else       lfsr <= prbs7_next(lfsr);
  end

  assign prbs_on = prbs_mode;
  assign raw     = prbs_mode ? lfsr[6] : shreg[7];
`else
  assign prbs_on = 1'b0;
  assign raw     = shreg[7];
`endif

  // in_ready depends on the bit counter only, never on in_valid
  assign boundary  = (bitcnt == 3'd7);
  assign in_ready  = boundary & ~prbs_on;
  assign take      = in_ready & in_valid;
  assign idle_ins  = in_ready & ~in_valid;
  assign frame_raw = (bitcnt == 3'd0);

  // bit position within the current word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) bitcnt <= 3'd0;
    else       bitcnt <= bitcnt + 3'd1;
  end

  // word shifter: shift inside a word, reload at the boundary
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         shreg <= IDLE_WORD;
    else if (boundary) shreg <= take ? word_t'(in_data) : IDLE_WORD;
    else               shreg <= {shreg[6:0], 1'b0};
  end

  // skew is retimed only at word boundaries so a word is never torn mid-flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         phase_q <= 3'd0;
    else if (boundary) phase_q <= phase_shift;
  end

  // saturating idle-word counter, clear wins over increment
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                               idle_cnt <= '0;
    else if (idle_clr)                       idle_cnt <= '0;
    else if (idle_ins && (idle_cnt != '1))   idle_cnt <= idle_cnt + 1'b1;
  end

  tmrg_bit_delay8 u_dly_data (
    .clk  (clk),
    .rstn (rstn),
    .din  (raw),
    .sel  (phase_q),
    .dout (sout)
  );

  tmrg_bit_delay8 u_dly_frame (
    .clk  (clk),
    .rstn (rstn),
    .din  (frame_raw),
    .sel  (phase_q),
    .dout (frame)
  );

endmodule

// File: tb/tb_tmrg_ser8_tx.sv
// Bench for tmrg_ser8_tx: scoreboard of expected serial bits plus directed
// captures of hand-computed bit windows.
module tb_tmrg_ser8_tx;
  import tmrg_ser8_tx_pkg::*;

  localparam logic [7:0] IDLE = 8'hBC;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] phase_shift = 3'd0;
  logic       sout;
  logic       frame;
  logic [7:0] idle_cnt;
  logic       idle_clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  logic mon_en = 1'b0;

  typedef struct packed {
    logic bit_v;
    logic frm;
    logic last;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  logic [7:0] hist_d;
  logic [7:0] hist_f;
  logic [2:0] phase_m;
  logic [7:0] exp_idle;
  logic       es, ef;

  tmrg_ser8_tx #(.IDLE_WORD(8'hBC), .CNT_W(8)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .phase_shift (phase_shift),
    .sout        (sout),
    .frame       (frame),
    .idle_cnt    (idle_cnt),
    .idle_clr    (idle_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    exp_t x;
    for (int i = 7; i >= 0; i--) begin
      x.bit_v = w[i];
      x.frm   = (i == 7);
      x.last  = (i == 0);
      q.push_back(x);
    end
  endtask

  task automatic reset_model();
    q.delete();
    push_word(IDLE);
    hist_d   = 8'h00;
    hist_f   = 8'h00;
    phase_m  = 3'd0;
    exp_idle = 8'h00;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // holds in_valid until the word is taken; returns at posedge+1 of the first bit cycle
  task automatic send(input logic [7:0] w);
    int n;
    n = 0;
    step(1);
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("send_ready_timeout", {31'd0, in_ready}, 32'd1);
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic capture(input int nb, output logic [15:0] d, output logic [15:0] f);
    d = 16'h0;
    f = 16'h0;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      d = {d[14:0], sout};
      f = {f[14:0], frame};
    end
  endtask

  // scoreboard monitor: one expected raw bit per cycle, retimed by the model skew
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow: got empty queue expected data at %0t", $time);
      end else begin
        e  = q.pop_front();
        es = (phase_m == 3'd0) ? e.bit_v : hist_d[phase_m - 3'd1];
        ef = (phase_m == 3'd0) ? e.frm   : hist_f[phase_m - 3'd1];
        check("sout", {31'd0, sout}, {31'd0, es});
        check("frame", {31'd0, frame}, {31'd0, ef});
        check("in_ready", {31'd0, in_ready}, {31'd0, e.last});
        hist_d = {hist_d[6:0], e.bit_v};
        hist_f = {hist_f[6:0], e.frm};
        if (e.last) phase_m = phase_shift;
      end
    end
  end

  // stimulus side: record each word transfer and the expected idle count
  always @(negedge clk) begin
    if (mon_en) begin
      check("idle_cnt", {24'd0, idle_cnt}, {24'd0, exp_idle});
      if (in_ready) push_word(in_valid ? in_data : IDLE);
      if (idle_clr) exp_idle = 8'h00;
      else if (in_ready && !in_valid && exp_idle != 8'hFF) exp_idle = exp_idle + 8'd1;
    end
  end

  initial begin
    logic [15:0] d, f;
    int n;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_sout", {31'd0, sout}, 32'd1);
    check("rst_frame", {31'd0, frame}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_idle_cnt", {24'd0, idle_cnt}, 32'd0);
    reset_model();
    rstn   = 1'b1;
    mon_en = 1'b1;

    // idle stream
    capture(8, d, f);
    check("idle_word0", {24'd0, d[7:0]}, 32'hBC);
    check("idle_frame0", {24'd0, f[7:0]}, 32'h80);
    capture(16, d, f);
    check("idle_words12", {16'd0, d}, 32'hBCBC);
    check("idle_cnt_after2", {24'd0, idle_cnt}, 32'd2);

    // back-to-back words, no skew
    send(8'hA5);
    fork
      send(8'h3C);
      capture(16, d, f);
    join
    check("p0_stream", {16'd0, d}, 32'hA53C);
    check("p0_frame", {16'd0, f}, 32'h8080);

    // same words, skew 5
    step(1);
    phase_shift = 3'd5;
    step(16);
    send(8'hA5);
    fork
      send(8'h3C);
      begin
        capture(5, d, f);
        capture(16, d, f);
      end
    join
    check("p5_stream", {16'd0, d}, 32'hA53C);
    check("p5_frame", {16'd0, f}, 32'h8080);

    // skew 2 -> 6 requested mid-word: the tap holds until the boundary
    step(1);
    phase_shift = 3'd2;
    step(16);
    send(8'hA5);
    fork
      begin
        step(3);
        phase_shift = 3'd6;
      end
      begin
        capture(2, d, f);
        capture(6, d, f);
      end
    join
    check("p2to6_stream", {26'd0, d[5:0]}, 32'b101001);
    check("p2to6_frame", {26'd0, f[5:0]}, 32'b100000);

    // idle counter saturation
    n = 0;
    while (idle_cnt != 8'hFF && n < 2500) begin
      @(negedge clk);
      n++;
    end
    check("sat_reach", {24'd0, idle_cnt}, 32'hFF);
    repeat (24) @(negedge clk);
    check("sat_hold", {24'd0, idle_cnt}, 32'hFF);

    // clear coinciding with an increment
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    check("clr_find_boundary", {31'd0, in_ready}, 32'd1);
    step(8);
    check("clr_pre", {24'd0, idle_cnt}, 32'hFF);
    idle_clr = 1'b1;
    step(1);
    idle_clr = 1'b0;
    check("clr_vs_inc", {24'd0, idle_cnt}, 32'h00);

    // reset at bit 3 of 8'h5A
    send(8'h5A);
    step(3);
    #1;
    rstn   = 1'b0;
    mon_en = 1'b0;
    #1;
    check("midrst_sout", {31'd0, sout}, 32'd1);
    check("midrst_frame", {31'd0, frame}, 32'd1);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_idle_cnt", {24'd0, idle_cnt}, 32'd0);
    step(2);
    reset_model();
    rstn   = 1'b1;
    mon_en = 1'b1;
    capture(8, d, f);
    check("midrst_first_word", {24'd0, d[7:0]}, 32'hBC);
    check("midrst_first_frame", {24'd0, f[7:0]}, 32'h80);
    step(20);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
